// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a 2**N_IN-entry operand sweep through an external
// combinational block, waits SETTLE_CYCLES per operand, samples the block's
// 1-bit result and assembles the complete truth table plus its population count.
module truth_table_scanner #(
   parameter int N_IN          = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 y_in,
   output logic [N_IN-1:0]      a_out,
   output logic                 busy,
   output logic                 done,
   output logic                 table_valid,
   output logic [2**N_IN-1:0]   table_out,
   output logic [N_IN:0]        ones_count
);

   localparam int              TW       = 2**N_IN;
   localparam logic [N_IN-1:0] A_LAST   = '1;
   localparam logic [7:0]      CNT_LAST = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [N_IN-1:0]   r_a,     w_a_nxt;
   logic [7:0]        r_cnt,   w_cnt_nxt;
   logic [TW-1:0]     r_table, w_table_nxt;
   logic [N_IN:0]     r_ones,  w_ones_nxt;
   logic              r_tv,    w_tv_nxt;
   logic              r_busy,  w_busy_nxt;
   logic              r_done,  w_done_nxt;

   // Next-state and next-datapath decode; abort overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_cnt_nxt   = r_cnt;
      w_table_nxt = r_table;
      w_ones_nxt  = r_ones;
      w_tv_nxt    = r_tv;
      unique case (r_state)
         S_IDLE: begin
            w_a_nxt = '0;
            if (start) begin
               w_table_nxt = '0;
               w_ones_nxt  = '0;
               w_tv_nxt    = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_SAMPLE;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_SAMPLE: begin
            w_table_nxt[r_a] = y_in;
            w_ones_nxt       = r_ones + (N_IN+1)'(y_in);
            if (r_a == A_LAST) begin
               w_tv_nxt    = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_a_nxt     = r_a + 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SETTLE;
            end
         end
         S_DONE: begin
            w_a_nxt     = '0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_a_nxt     = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
      // A cancelled scan must never look complete, so the valid flag is frozen.
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_a_nxt     = '0;
         w_cnt_nxt   = '0;
         w_tv_nxt    = r_tv;
      end
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand, counter, table and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_cnt   <= '0;
         r_table <= '0;
         r_ones  <= '0;
         r_tv    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_a     <= w_a_nxt;
         r_cnt   <= w_cnt_nxt;
         r_table <= w_table_nxt;
         r_ones  <= w_ones_nxt;
         r_tv    <= w_tv_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign a_out       = r_a;
   assign busy        = r_busy;
   assign done        = r_done;
   assign table_valid = r_tv;
   assign table_out   = r_table;
   assign ones_count  = r_ones;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (settle 2 and settle 1), table of
// truth functions plus random masks, timeline model derived from scan rules.
module tb_truth_table_scanner;

   logic clk;
   int   checks = 0;
   int   errors = 0;
   int   sel    = 0;

   // instance 0: SETTLE_CYCLES=2
   logic        rst0_n, st0, ab0, y0;
   logic [3:0]  a0;
   logic        busy0, done0, tv0;
   logic [15:0] tab0, mask0;
   logic [4:0]  ones0;
   // instance 1: SETTLE_CYCLES=1
   logic        rst1_n, st1, ab1, y1;
   logic [3:0]  a1;
   logic        busy1, done1, tv1;
   logic [15:0] tab1, mask1;
   logic [4:0]  ones1;

   // the "combinational block under scan" is a lookup into a truth mask
   assign y0 = mask0[a0];
   assign y1 = mask1[a1];

   truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(2)) u_dut0 (
      .clk(clk), .rst_n(rst0_n), .start(st0), .abort(ab0), .y_in(y0),
      .a_out(a0), .busy(busy0), .done(done0), .table_valid(tv0),
      .table_out(tab0), .ones_count(ones0));

   truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .start(st1), .abort(ab1), .y_in(y1),
      .a_out(a1), .busy(busy1), .done(done1), .table_valid(tv1),
      .table_out(tab1), .ones_count(ones1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  o_a;
   logic        o_busy, o_done, o_tv;
   logic [15:0] o_tab;
   logic [4:0]  o_ones;
   assign o_a    = (sel != 0) ? a1    : a0;
   assign o_busy = (sel != 0) ? busy1 : busy0;
   assign o_done = (sel != 0) ? done1 : done0;
   assign o_tv   = (sel != 0) ? tv1   : tv0;
   assign o_tab  = (sel != 0) ? tab1  : tab0;
   assign o_ones = (sel != 0) ? ones1 : ones0;

   typedef struct {
      logic [15:0] mask;
      logic [15:0] exp_tab;
      logic [4:0]  exp_ones;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) st1 = v; else st0 = v;
   endtask

   task automatic set_abort(input logic v);
      if (sel != 0) ab1 = v; else ab0 = v;
   endtask

   task automatic set_rst(input logic v);
      if (sel != 0) rst1_n = v; else rst0_n = v;
   endtask

   task automatic set_mask(input logic [15:0] m);
      if (sel != 0) mask1 = m; else mask0 = m;
   endtask

   // Reference: bit k of the table is the function value at operand k.
   function automatic logic [15:0] ref_table(input logic [15:0] m);
      logic [15:0] t;
      for (int k = 0; k < 16; k++) t[k] = m[k];
      return t;
   endfunction

   function automatic logic [4:0] ref_ones(input logic [15:0] m);
      int n = 0;
      for (int k = 0; k < 16; k++) if (m[k]) n++;
      return 5'(n);
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Full scan with a per-edge timeline check. Each operand occupies S edges.
   task automatic run_scan(input logic [15:0] m, input logic [15:0] et,
                           input logic [4:0] eo, input bit repulse);
      int S;
      int total;
      int exp_a;
      int bad_a, bad_b, bad_d;
      S     = (sel != 0) ? 2 : 3;
      total = 16 * S;
      bad_a = 0; bad_b = 0; bad_d = 0;
      set_mask(m);
      set_start(1'b1);
      step();
      set_start(1'b0);
      chk("busy_at_E0", {31'b0, o_busy}, 32'd1);
      chk("tv_cleared_at_start", {31'b0, o_tv}, 32'd0);
      chk("a_at_E0", {28'b0, o_a}, 32'd0);
      for (int t = 1; t <= total + 1; t++) begin
         if (repulse)
            set_start((t == 5) || (t == 20) || (t == total + 1) ||
                      ($urandom_range(0, 5) == 0));
         step();
         set_start(1'b0);
         exp_a = (t < total) ? (t / S) : ((t == total) ? 15 : 0);
         if (o_a !== 4'(exp_a)) begin
            bad_a++;
            if (bad_a == 1) $display("FAIL a_seq t=%0d: got %0d expected %0d", t, o_a, exp_a);
         end
         if (o_busy !== (t <= total)) begin
            bad_b++;
            if (bad_b == 1) $display("FAIL busy_seq t=%0d: got %0b expected %0b", t, o_busy, (t <= total));
         end
         if (o_done !== (t == total)) begin
            bad_d++;
            if (bad_d == 1) $display("FAIL done_seq t=%0d: got %0b expected %0b", t, o_done, (t == total));
         end
      end
      checks += 3;
      if (bad_a != 0) errors++;
      if (bad_b != 0) errors++;
      if (bad_d != 0) errors++;
      chk("table_out", {16'b0, o_tab}, {16'b0, et});
      chk("ones_count", {27'b0, o_ones}, {27'b0, eo});
      chk("table_valid", {31'b0, o_tv}, 32'd1);
   endtask

   initial begin
      logic [15:0] rm;
      int dcount;
      rst0_n = 1'b0; rst1_n = 1'b0;
      st0 = 1'b0; st1 = 1'b0; ab0 = 1'b0; ab1 = 1'b0;
      mask0 = '0; mask1 = '0;

      vecs[0] = '{16'h6996, 16'h6996, 5'd8};   // parity
      vecs[1] = '{16'h8000, 16'h8000, 5'd1};   // AND-reduce
      vecs[2] = '{16'hFFFF, 16'hFFFF, 5'd16};  // constant 1
      vecs[3] = '{16'h0000, 16'h0000, 5'd0};   // constant 0
      vecs[4] = '{16'h0001, 16'h0001, 5'd1};   // only operand 0
      for (int i = 5; i < 7; i++) begin
         rm = 16'($urandom);
         vecs[i] = '{rm, ref_table(rm), ref_ones(rm)};
      end

      // reset then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst0_n = 1'b1; rst1_n = 1'b1;
      repeat (10) step();
      sel = 0;
      chk("rst_a", {28'b0, o_a}, 32'd0);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      chk("rst_done", {31'b0, o_done}, 32'd0);
      chk("rst_tv", {31'b0, o_tv}, 32'd0);
      chk("rst_table", {16'b0, o_tab}, 32'd0);
      chk("rst_ones", {27'b0, o_ones}, 32'd0);

      // table-driven scans, settle 2
      for (int i = 0; i < 7; i++) begin
         run_scan(vecs[i].mask, vecs[i].exp_tab, vecs[i].exp_ones, (i == 1));
         repeat (2) step();
      end

      // abort at cycle 20
      set_mask(16'h6996);
      set_start(1'b1);
      step();
      set_start(1'b0);
      repeat (19) step();
      set_abort(1'b1);
      step();
      set_abort(1'b0);
      chk("abort_busy", {31'b0, o_busy}, 32'd0);
      chk("abort_a", {28'b0, o_a}, 32'd0);
      chk("abort_done", {31'b0, o_done}, 32'd0);
      chk("abort_tv", {31'b0, o_tv}, 32'd0);
      dcount = 0;
      for (int t = 0; t < 60; t++) begin
         step();
         if (o_done || o_busy) dcount++;
      end
      chk("abort_no_done", dcount, 32'd0);
      // abort in IDLE has no effect, then a full scan
      set_abort(1'b1);
      step();
      set_abort(1'b0);
      chk("abort_idle_busy", {31'b0, o_busy}, 32'd0);
      rm = 16'($urandom);
      run_scan(rm, ref_table(rm), ref_ones(rm), 1'b1);

      // async reset at cycle 30, between edges
      set_mask(16'hA5A5);
      set_start(1'b1);
      step();
      set_start(1'b0);
      repeat (29) step();
      chk("pre_reset_busy", {31'b0, o_busy}, 32'd1);
      #1;
      set_rst(1'b0);
      #1;
      chk("async_busy", {31'b0, o_busy}, 32'd0);
      chk("async_a", {28'b0, o_a}, 32'd0);
      chk("async_table", {16'b0, o_tab}, 32'd0);
      chk("async_ones", {27'b0, o_ones}, 32'd0);
      chk("async_done_tv", {30'b0, o_done, o_tv}, 32'd0);
      @(negedge clk);
      set_rst(1'b1);
      repeat (5) step();
      chk("post_reset_idle", {31'b0, o_busy}, 32'd0);

      // settle-1 variant
      sel = 1;
      run_scan(16'h6996, 16'h6996, 5'd8, 1'b0);
      repeat (2) step();
      for (int i = 0; i < 3; i++) begin
         rm = 16'($urandom);
         run_scan(rm, ref_table(rm), ref_ones(rm), 1'b1);
         repeat (2) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/capture stage wrapped around a small combinational function block (4-bit input, 1-bit output).
- Upstream role: on `start`, steps the 4-bit operand `a_out` through every code 0..2**N_IN-1.
- Downstream role: samples the block's 1-bit result `y_in` after a programmable settle time and assembles the full truth table into a register.
- Replaces free-running bench loops with a synthesizable, handshaked scanner usable in silicon self-check.

Parameters:
- N_IN, 4, operand width; table width is 2**N_IN.
- SETTLE_CYCLES, 2, cycles `a_out` is held before `y_in` is sampled; legal range 1..255.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  scan request; accepted only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE.
- y_in  input  1  result from the combinational block under scan.
- a_out  output  N_IN  operand driven to the block under scan.
- busy  output  1  high while a scan is in progress (SETTLE/SAMPLE/DONE).
- done  output  1  one-cycle pulse when the table is complete.
- table_valid  output  1  sticky high after a completed scan; cleared on next accepted start.
- table_out  output  2**N_IN  bit k = y_in sampled while a_out==k.
- ones_count  output  N_IN+1  number of 1s in table_out.

Behaviour:
- Reset (rst_n low, async): state=IDLE; a_out=0, busy=0, done=0, table_valid=0, table_out=0, ones_count=0, settle counter=0.
- All outputs are registered. done=(state==DONE); busy=(state!=IDLE).
- IDLE: a_out held at 0.
  - On start=1 at edge E0: table_out=0, ones_count=0, table_valid=0, cnt=0, a_out=0, go to SETTLE.
- SETTLE: if cnt==SETTLE_CYCLES-1, go to SAMPLE; else cnt++. a_out is stable throughout.
- SAMPLE (one cycle):
  - table_out[a_out]<=y_in; ones_count<=ones_count+y_in.
  - If a_out==2**N_IN-1: go to DONE and set table_valid=1 on the same edge.
  - Else: a_out++, cnt=0, go to SETTLE.
- DONE (one cycle): done=1. Next edge: IDLE, a_out=0.
- Latency: each vector takes SETTLE_CYCLES+1 edges.
  - The last sample lands at edge E0+2**N_IN*(SETTLE_CYCLES+1).
  - done is high for exactly the following cycle.
  - For defaults: last sample at E48; done high between E48 and E49; busy low from E49.
- start while busy is ignored, including in the DONE cycle; no queuing.
- start in the same cycle that DONE returns to IDLE is not seen until IDLE is registered.
- abort has priority over start and over all state transitions.
  - In any non-IDLE state: next edge goes to IDLE, a_out=0, busy=0, no done pulse.
  - table_valid stays 0; table_out and ones_count keep their partial values (undefined for use).
  - abort in IDLE has no effect.
- ones_count never wraps: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- a_out never wraps past 2**N_IN-1 within a scan.
- Reset asserted mid-scan clears everything immediately (async). Scanning resumes only on a new start after rst_n deasserts.
- y_in is treated as synchronous to clk and is sampled only in SAMPLE. Its value in other states is don't-care.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, start=0 for 10 cycles -> a_out=0, busy=0, done=0, table_valid=0, table_out=0.
- Parity model (y_in=^a_out), defaults, start pulse at E0:
  - busy high from E0.
  - a_out sequence 0..15, each held 3 cycles.
  - done single pulse after E48.
  - table_out=16'h6996, ones_count=8, table_valid=1.
- AND-reduce model (y_in=&a_out) -> table_out=16'h8000, ones_count=1. Rescan with constant y_in=1 -> table_valid drops at the new start, then table_out=16'hFFFF, ones_count=16.
- start re-pulsed at cycles 5, 20 and 48 of a scan -> ignored; exactly one done pulse; timing identical to the single-start case.
- abort mid-scan: abort at cycle 20 -> IDLE next edge, busy=0, a_out=0, no done, table_valid=0. A following start produces a correct full scan.
- Async reset at cycle 30 (between edges) -> outputs zero immediately, before the next edge. SETTLE_CYCLES=1 variant -> done after E32, table correct.
